mem_arbiter: RTL

- Shares the single memory port between instruction fetch (IFU) and execute-stage load/store traffic (LSU).
- Sits between the IFU/EXU memory request outputs and the memfile.
- Arbitrates 2-way round-robin and keeps one transaction outstanding.
- Re-issues the winning request on the memory-side valid/ready handshake, routes the response back to its owner, and returns an error response if memory fails to answer within a bounded number of cycles.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_arbiter_if.sv | 29 ++
 rtl/mem_arbiter_rr_arb2.sv | 17 +
 rtl/mem_arbiter.sv | 86 ++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and widths for the IFU/LSU memory arbiter
package mem_arb_pkg;
  localparam int MEM_ADDR_W = 32;
  localparam int MEM_DATA_W = 32;
  localparam int MEM_MASK_W = 4;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;
  typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IFU, LSU and memfile handshake bundle around the arbiter
interface mem_arbiter_if;
  import mem_arb_pkg::*;
  logic                  ifu_req_i, ifu_gnt_o, ifu_rvalid_o, ifu_err_o;
  logic [MEM_ADDR_W-1:0] ifu_addr_i;
  logic [MEM_DATA_W-1:0] ifu_rdata_o;
  logic                  lsu_req_i, lsu_wen_i, lsu_gnt_o, lsu_rvalid_o, lsu_err_o;
  logic [MEM_ADDR_W-1:0] lsu_addr_i;
  logic [MEM_DATA_W-1:0] lsu_wdata_i, lsu_rdata_o;
  logic [MEM_MASK_W-1:0] lsu_wmask_i;
  logic                  mem_req_o, mem_wen_o, mem_gnt_i, mem_rvalid_i;
  logic [MEM_ADDR_W-1:0] mem_addr_o;
  logic [MEM_DATA_W-1:0] mem_wdata_o, mem_rdata_i;
  logic [MEM_MASK_W-1:0] mem_wmask_o;
  modport slave (
    input  ifu_req_i, ifu_addr_i, lsu_req_i, lsu_wen_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
           lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
           mem_req_o, mem_addr_o, mem_wdata_o, mem_wmask_o, mem_wen_o
  );
  modport master (
    output ifu_req_i, ifu_addr_i, lsu_req_i, lsu_wen_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
           mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
           lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
           mem_req_o, mem_addr_o, mem_wdata_o, mem_wmask_o, mem_wen_o
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker; bit 0 = IFU, bit 1 = LSU
module rr_arb2 import mem_arb_pkg::*; (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  owner_e last_grant;
  logic pick_lsu;
  assign pick_lsu = req_i[1] && (!req_i[0] || last_grant == OWN_IFU);
  assign gnt_o = en_i ? {pick_lsu, req_i[0] && !pick_lsu} : 2'b00;
  always_ff @(posedge clk_i) begin
    if (rst_i) last_grant <= OWN_IFU;
    else if (|gnt_o) last_grant <= pick_lsu ? OWN_LSU : OWN_IFU;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memfile port between IFU and LSU, one transaction in flight, with timeout
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int TIMEOUT_CYC = 255
) (
  input logic          clk_i,
  input logic          rst_i,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  state_e                state, state_nxt;
  owner_e                owner;
  logic [1:0]            gnt;
  logic [CNT_W-1:0]      cnt;
  logic                  take, busy, timeout, mem_done, ifu_rv, lsu_rv, wen_q, err_q;
  logic [MEM_ADDR_W-1:0] addr_q;
  logic [MEM_DATA_W-1:0] wdata_q, rdata_q;
  logic [MEM_MASK_W-1:0] wmask_q;
  rr_arb2 u_rr (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (state == IDLE),
    .req_i ({bus.lsu_req_i, bus.ifu_req_i}),
    .gnt_o (gnt)
  );
  assign take     = |gnt;
  assign busy     = state == REQ || state == WAIT;
  assign timeout  = busy && cnt >= CNT_LAST;
  assign mem_done = state == WAIT && bus.mem_rvalid_i;
  // a memory event in the final counted cycle takes priority over the timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    state_nxt = take ? REQ : IDLE;
      REQ:     state_nxt = bus.mem_gnt_i ? WAIT : timeout ? RESP : REQ;
      WAIT:    state_nxt = bus.mem_rvalid_i || timeout ? RESP : WAIT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      owner   <= OWN_IFU;
      cnt     <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      wen_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= !busy ? '0 : cnt == CNT_MAX ? cnt : cnt + 1'b1;
      if (take) begin
        owner   <= gnt[1] ? OWN_LSU : OWN_IFU;
        addr_q  <= gnt[1] ? bus.lsu_addr_i : bus.ifu_addr_i;
        wdata_q <= gnt[1] ? bus.lsu_wdata_i : '0;
        wmask_q <= gnt[1] && bus.lsu_wen_i ? bus.lsu_wmask_i : '0;
        wen_q   <= gnt[1] && bus.lsu_wen_i;
      end
      if (mem_done) begin
        rdata_q <= wen_q ? '0 : bus.mem_rdata_i;
        err_q   <= 1'b0;
      end else if (busy && state_nxt == RESP) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end
  assign ifu_rv           = state == RESP && owner == OWN_IFU;
  assign lsu_rv           = state == RESP && owner == OWN_LSU;
  assign bus.ifu_gnt_o    = gnt[0];
  assign bus.lsu_gnt_o    = gnt[1];
  assign bus.ifu_rvalid_o = ifu_rv;
  assign bus.lsu_rvalid_o = lsu_rv;
  assign bus.ifu_rdata_o  = ifu_rv ? rdata_q : '0;
  assign bus.lsu_rdata_o  = lsu_rv ? rdata_q : '0;
  assign bus.ifu_err_o    = ifu_rv && err_q;
  assign bus.lsu_err_o    = lsu_rv && err_q;
  assign bus.mem_req_o    = state == REQ;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.mem_wmask_o  = wmask_q;
  assign bus.mem_wen_o    = wen_q;
endmodule
